// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Holds the program counter, drives a combinational
//   instruction ROM and captures the returned word into the IF/ID register.
//   That register is handed to decode over a valid/ready handshake. A
//   redirect from downstream flushes the wrong-path instruction and reloads
//   the PC.
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target traps into a sticky FAULT state.
//   undefined : target[1:0] is forced to 00 and fault/fault_pc are tied to 0.
//
// Parameters
//   ADDR_BITS      byte-address width of the PC
//   ROM_ADDR_BITS  word-address width of the ROM
//   DATA_BITS      instruction width
//   RESET_PC       PC value after reset
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   rom_addr/rom_sel  ROM word address / enable (enable only in RUN)
//   rom_dout          ROM data, same cycle as rom_addr
//   redirect_valid    branch/jump taken this cycle
//   redirect_target   new PC on redirect
//   id_ready          decode accepts the IF/ID register
//   id_valid          IF/ID register holds a valid instruction
//   id_instr          fetched instruction
//   id_pc, id_pc4     PC of id_instr and PC+4
//   fetch_count       instructions accepted into IF/ID since reset
//   fault, fault_pc   sticky misaligned-redirect fault and offending target
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned        ADDR_BITS     = 32,
    parameter int unsigned        ROM_ADDR_BITS = 10,
    parameter int unsigned        DATA_BITS     = 32,
    parameter logic [ADDR_BITS-1:0] RESET_PC    = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    output logic                     rom_sel,
    input  logic [DATA_BITS-1:0]     rom_dout,
    input  logic                     redirect_valid,
    input  logic [ADDR_BITS-1:0]     redirect_target,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [DATA_BITS-1:0]     id_instr,
    output logic [ADDR_BITS-1:0]     id_pc,
    output logic [ADDR_BITS-1:0]     id_pc4,
    output logic [31:0]              fetch_count,
    output logic                     fault,
    output logic [ADDR_BITS-1:0]     fault_pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_BITS-1:0]   r_pc;
    logic                   r_id_valid;
    logic [DATA_BITS-1:0]   r_id_instr;
    logic [ADDR_BITS-1:0]   r_id_pc;
    logic [31:0]            r_fetch_count;

    logic                   w_run;
    logic                   w_redirect;
    logic                   w_misalign;
    logic                   w_fire;
    logic [ADDR_BITS-1:0]   w_target_aligned;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     if (w_redirect && w_misalign) w_state_nxt = FAULT;
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_run      = (r_state == RUN);
        rom_sel    = w_run;
        w_redirect = w_run && redirect_valid;
        // Redirect outranks fetch; fetch needs an empty or draining IF/ID.
        w_fire     = w_run && !redirect_valid && (!r_id_valid || id_ready);
    end

`ifdef IF_MISALIGN_TRAP_EN
    assign w_misalign = (redirect_target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
    // Low target bits are discarded when the trap is compiled out.
    logic w_unused_target_lsbs;
    assign w_unused_target_lsbs = ^redirect_target[1:0];
`endif

    assign w_target_aligned = {redirect_target[ADDR_BITS-1:2], 2'b00};

    // ------------------------------------------------------------------
    // PC and IF/ID pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= '0;
            r_id_pc       <= '0;
            r_fetch_count <= '0;
        end else if (w_redirect) begin
            // Flush regardless of id_ready; a trapping redirect keeps the PC.
            r_id_valid <= 1'b0;
            if (!w_misalign) begin
                r_pc <= w_target_aligned;
            end
        end else if (w_fire) begin
            r_id_instr    <= rom_dout;
            r_id_pc       <= r_pc;
            r_id_valid    <= 1'b1;
            r_pc          <= r_pc + ADDR_BITS'(4);
            r_fetch_count <= r_fetch_count + 32'd1;
        end else if (r_id_valid && id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky fault capture
    // ------------------------------------------------------------------
`ifdef IF_MISALIGN_TRAP_EN
    logic                 r_fault;
    logic [ADDR_BITS-1:0] r_fault_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (w_redirect && w_misalign) begin
            r_fault    <= 1'b1;
            r_fault_pc <= redirect_target;
        end
    end

    assign fault    = r_fault;
    assign fault_pc = r_fault_pc;
`else
    assign fault    = 1'b0;
    assign fault_pc = '0;
`endif

    assign rom_addr    = r_pc[ROM_ADDR_BITS+1:2];
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc4      = r_id_pc + ADDR_BITS'(4);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch (ROM_ADDR_BITS = 12). The ROM returns
//   32'h1000_0000 + word_index. A transaction-level reference model tracks
//   the program counter, the IF/ID contents and the fetch count. It is
//   compared against every DUT output after each clock edge, first over
//   directed scenarios and then over a randomized run.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int unsigned AB  = 32;
    localparam int unsigned RAB = 12;
    localparam int unsigned DB  = 32;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [RAB-1:0]  rom_addr;
    logic            rom_sel;
    logic [DB-1:0]   rom_dout;
    logic            redirect_valid;
    logic [AB-1:0]   redirect_target;
    logic            id_ready;
    logic            id_valid;
    logic [DB-1:0]   id_instr;
    logic [AB-1:0]   id_pc;
    logic [AB-1:0]   id_pc4;
    logic [31:0]     fetch_count;
    logic            fault;
    logic [AB-1:0]   fault_pc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;

    // Behavioural ROM: word i holds 32'h1000_0000 + i, zero when disabled.
    assign rom_dout = rom_sel ? (32'h1000_0000 + {20'd0, rom_addr}) : '0;

    instr_fetch #(
        .ADDR_BITS     (AB),
        .ROM_ADDR_BITS (RAB),
        .DATA_BITS     (DB),
        .RESET_PC      (RPC)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_addr        (rom_addr),
        .rom_sel         (rom_sel),
        .rom_dout        (rom_dout),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc4          (id_pc4),
        .fetch_count     (fetch_count),
        .fault           (fault),
        .fault_pc        (fault_pc)
    );

    // ------------------------------------------------------------------
    // Reference model (spec-level: "booted", "trapped", pc, IF/ID slot)
    // ------------------------------------------------------------------
`ifdef IF_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    bit          m_booted;
    bit          m_trapped;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_count;
    logic [31:0] m_fault_pc;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h0000_0FFF);
    endfunction

    task automatic model_tick(input bit rst, input bit rv,
                              input logic [31:0] tgt, input bit rdy);
        if (!rst) begin
            m_booted = 0; m_trapped = 0; m_pc = RPC; m_valid = 0;
            m_instr = 0; m_idpc = 0; m_count = 0; m_fault_pc = 0;
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (m_trapped) begin
            if (m_valid && rdy) m_valid = 0;
        end else if (rv) begin
            m_valid = 0;
            if (TRAP && tgt[1:0] != 2'b00) begin
                m_trapped  = 1;
                m_fault_pc = tgt;
            end else begin
                m_pc = tgt & 32'hFFFF_FFFC;
            end
        end else if (!m_valid || rdy) begin
            m_instr = rom_word(m_pc);
            m_idpc  = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rom_sel",     32'(rom_sel),  32'(m_booted && !m_trapped));
        chk("rom_addr",    32'(rom_addr), (m_pc >> 2) & 32'h0000_0FFF);
        chk("id_valid",    32'(id_valid), 32'(m_valid));
        chk("id_instr",    id_instr,      m_instr);
        chk("id_pc",       id_pc,         m_idpc);
        chk("id_pc4",      id_pc4,        m_idpc + 32'd4);
        chk("fetch_count", fetch_count,   m_count);
        chk("fault",       32'(fault),    32'(m_trapped));
        chk("fault_pc",    fault_pc,      m_fault_pc);
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic step(input bit rst, input bit rv,
                        input logic [31:0] tgt, input bit rdy);
        rst_n           = rst;
        redirect_valid  = rv;
        redirect_target = tgt;
        id_ready        = rdy;
        model_tick(rst, rv, tgt, rdy);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0; id_ready = 1'b1;

        // Reset held, then streaming from RESET_PC with decode always ready.
        repeat (3) step(0, 0, 32'h0, 1);
        repeat (8) step(1, 0, 32'h0, 1);

        // Three-cycle stall, then release.
        repeat (3) step(1, 0, 32'h0, 0);
        repeat (3) step(1, 0, 32'h0, 1);

        // Redirect while stalled: stalled instruction discarded.
        step(1, 0, 32'h0, 0);
        step(1, 1, 32'h0000_3040, 0);
        repeat (4) step(1, 0, 32'h0, 1);

        // PC wrap at the top of the address space, rom_addr aliasing.
        step(1, 1, 32'hFFFF_FFF0, 1);
        repeat (7) step(1, 0, 32'h0, 1);

        // Misaligned redirect: trap or silent alignment depending on build.
        step(1, 1, 32'h0000_3042, 1);
        repeat (5) step(1, 0, 32'h0, 1);
        step(1, 1, 32'h0000_4000, 1);  // ignored if trapped
        repeat (2) step(1, 0, 32'h0, 1);

        // One-cycle reset during streaming, with a redirect pending.
        step(0, 1, 32'h0000_5000, 1);
        repeat (5) step(1, 0, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst;
            bit          r_rv;
            bit          r_rdy;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) != 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_tgt = $urandom;
            if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) r_tgt[31:16] = 16'h0000;
            step(r_rst, r_rv, r_tgt, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS core. Holds the program counter, drives the combinational instruction ROM (`rom_addr`, `rom_sel`), captures the returned word into the IF/ID pipeline register and hands it to decode over a valid/ready handshake. Branch/jump redirects from downstream flush the wrong-path fetch and reload the PC.

## Interface
- `ADDR_BITS`, 32: byte-address width of the PC.
- `ROM_ADDR_BITS`, 10: word-address width of the ROM this stage drives.
- `DATA_BITS`, 32: instruction width.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rom_addr` out ROM_ADDR_BITS: word address to ROM, `pc[ROM_ADDR_BITS+1:2]`.
- `rom_sel` out 1: ROM enable.
- `rom_dout` in DATA_BITS: ROM data, valid in the same cycle as `rom_addr`/`rom_sel`.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_target` in ADDR_BITS: new PC on redirect.
- `id_ready` in 1: decode can accept the IF/ID register contents.
- `id_valid` out 1: IF/ID register holds a valid instruction.
- `id_instr` out DATA_BITS: fetched instruction.
- `id_pc` out ADDR_BITS: PC of `id_instr`.
- `id_pc4` out ADDR_BITS: `id_pc + 4`.
- `fetch_count` out 32: number of instructions accepted into IF/ID since reset.
- `fault` out 1: misaligned-redirect fault (sticky).
- `fault_pc` out ADDR_BITS: offending target.

## Operation
- States: BOOT, RUN, FAULT. Reset → BOOT. BOOT → RUN after exactly one cycle. RUN → FAULT only on misaligned redirect (see Configuration). FAULT exits only on reset.
- `rom_sel` = 1 only in RUN; 0 in BOOT/FAULT (ROM then returns 0, ignored).
- `fire` = RUN && !redirect_valid && (!id_valid || id_ready). On fire: `id_instr`←`rom_dout`, `id_pc`←pc, `id_valid`←1, pc←pc+4, `fetch_count`+1.
- Not fire, `id_valid && id_ready`: `id_valid`←0. Not fire, not ready: IF/ID register and pc held (stall).
- Redirect (RUN, aligned target): pc←`{target[ADDR_BITS-1:2],2'b00}`, `id_valid`←0 (flush, regardless of `id_ready`), no fetch that cycle, count unchanged. Redirect in BOOT or FAULT is ignored.
- Priority: reset > redirect > stall > fetch.
- PC arithmetic modulo 2^ADDR_BITS: 32'hFFFF_FFFC + 4 → 0. `rom_addr` truncates; PCs beyond ROM size alias modulo 2^ROM_ADDR_BITS words. `fetch_count` wraps 32'hFFFF_FFFF → 0.
- `id_pc4` is combinational from `id_pc`.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, `id_valid`=0, `id_instr`=0, `id_pc`=0, `fetch_count`=0, `fault`=0, `fault_pc`=0; `rom_sel`=0 during and one cycle after reset.
- First `id_valid`=1 appears 2 cycles after `rst_n` rises (BOOT cycle, then fetch edge), carrying `id_pc`=RESET_PC.
- Fetch latency: 1 cycle from pc to `id_instr`. Throughput 1 instr/cycle while `id_ready`=1.
- Redirect asserted in cycle N: `id_valid`=0 in N+1, instruction at target valid in N+2.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at that edge; pending redirect discarded.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined: redirect in RUN with `target[1:0]`≠0 → state FAULT, `fault`←1, `fault_pc`←target, `id_valid`←0, pc unchanged; no further fetches until reset.
- Not defined: `target[1:0]` silently forced to 00, FAULT unreachable, `fault`/`fault_pc` tied to 0.

## Test plan
- Reset release, ROM word i = 32'h1000_0000+i, `id_ready`=1: `id_valid` rises 2 cycles after reset, `id_pc` = 3000, 3004, 3008…, `id_instr` = ROM[0xC00], ROM[0xC01]… (ROM_ADDR_BITS=12), `fetch_count` increments each cycle.
- Hold `id_ready`=0 for 3 cycles with `id_valid`=1: `id_instr`, `id_pc`, pc, `fetch_count` frozen; on release next instruction follows with no skip or duplicate.
- Redirect to 32'h0000_3040 while stalled: next cycle `id_valid`=0, following cycle `id_pc`=3040; stalled instruction discarded, count not incremented for flush cycle.
- PC at 32'hFFFF_FFFC: next `id_pc`=0; `rom_addr` aliases correctly.
- Redirect to 32'h0000_3042: with `IF_MISALIGN_TRAP_EN`, `fault`=1, `fault_pc`=3042, `id_valid`=0, `rom_sel`=0 until reset; without it, `id_pc`=3040 two cycles later, `fault`=0.
- Assert `rst_n`=0 for one cycle during streaming: all outputs return to reset values next edge; restart from RESET_PC.
